// File: rtl/bldc_pkg.sv
// rtl/bldc_pkg.sv - shared state codes, fault codes and six-step Hall helpers
package bldc_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ALIGN = 3'd1;
   localparam logic [2:0] ST_RAMP  = 3'd2;
   localparam logic [2:0] ST_RUN   = 3'd3;
   localparam logic [2:0] ST_FAULT = 3'd4;

   localparam logic [1:0] FC_NONE  = 2'b00;
   localparam logic [1:0] FC_STALL = 2'b01;
   localparam logic [1:0] FC_HALL  = 2'b10;
   localparam logic [1:0] FC_START = 2'b11;

   localparam logic [2:0] FWD_ORDER [0:5] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

   function automatic logic [2:0] hall_to_phase(input logic [2:0] h);
      case (h)
         3'b001:  return 3'b001;
         3'b011:  return 3'b010;
         3'b010:  return 3'b100;
         3'b110:  return 3'b001;
         3'b100:  return 3'b010;
         3'b101:  return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [2:0] hall_next(input logic [2:0] h);
      case (h)
         3'b001:  return 3'b011;
         3'b011:  return 3'b010;
         3'b010:  return 3'b110;
         3'b110:  return 3'b100;
         3'b100:  return 3'b101;
         3'b101:  return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic hall_valid(input logic [2:0] h);
      return (h != 3'b000) && (h != 3'b111);
   endfunction

endpackage

// File: rtl/hall_debounce.sv
// rtl/hall_debounce.sv - Hall synchroniser and stability filter with edge strobe
module hall_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] hall_raw,
   output logic [2:0] hall_db,
   output logic [2:0] hall_prev,
   output logic       hall_edge
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [2:0]    sync1;
   logic [2:0]    sync2;
   logic [2:0]    cand;
   logic [DW-1:0] cnt;
   logic [DW-1:0] cnt_n;
   logic          accept;

   // cnt_n is how many cycles sync2 will have held its value including this one
   always_comb begin
      cnt_n  = '0;
      accept = 1'b0;
      if (sync2 != cand)
         cnt_n = DW'(1);
      else if (cnt == DW'(DEBOUNCE_CYCLES))
         cnt_n = cnt;
      else
         cnt_n = cnt + 1'b1;
      accept = (cnt_n == DW'(DEBOUNCE_CYCLES)) && (sync2 != hall_db);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1     <= '0;
         sync2     <= '0;
         cand      <= '0;
         cnt       <= '0;
         hall_db   <= '0;
         hall_prev <= '0;
         hall_edge <= 1'b0;
      end else begin
         sync1     <= hall_raw;
         sync2     <= sync1;
         cand      <= sync2;
         cnt       <= cnt_n;
         hall_edge <= accept;
         if (accept) begin
            hall_db   <= sync2;
            hall_prev <= hall_db;
         end
      end
   end

endmodule

// File: rtl/bldc_comm_sequencer.sv
// rtl/bldc_comm_sequencer.sv - six-step BLDC startup/run sequencer with fault supervision
import bldc_pkg::*;

module bldc_comm_sequencer #(
   parameter int DEBOUNCE_CYCLES  = 4,
   parameter int ALIGN_CYCLES     = 1000,
   parameter int RAMP_STEP_CYCLES = 2000,
   parameter int RAMP_STEPS_MAX   = 24,
   parameter int HANDOFF_EDGES    = 3,
   parameter int STALL_CYCLES     = 65535,
   parameter int PERIOD_W         = 20
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                clear_fault,
   input  logic [2:0]          hall_raw,
   output logic [2:0]          phase_en,
   output logic [2:0]          state,
   output logic                running,
   output logic                fault,
   output logic [1:0]          fault_code,
   output logic [PERIOD_W-1:0] speed_period,
   output logic                period_valid
);
   localparam int CW = $clog2((ALIGN_CYCLES > RAMP_STEP_CYCLES ? ALIGN_CYCLES : RAMP_STEP_CYCLES) + 1);
   localparam int SW = $clog2(RAMP_STEPS_MAX + 1);
   localparam int HW = $clog2(HANDOFF_EDGES + 1);
   localparam int TW = $clog2(STALL_CYCLES + 1);

   logic [2:0]          hall_db;
   logic [2:0]          hall_prev;
   logic                hall_edge;

   logic [CW-1:0]       cyc_q, cyc_n;
   logic [2:0]          idx_q, idx_n;
   logic [SW-1:0]       steps_q, steps_n;
   logic [HW-1:0]       hand_q, hand_n;
   logic [PERIOD_W-1:0] per_q, per_n;
   logic [TW-1:0]       stall_q, stall_n;
   logic [2:0]          st_n, ph_n;
   logic [1:0]          fc_n;
   logic [PERIOD_W-1:0] sp_n;
   logic                pv_n, fwd_edge, step_done;

   hall_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hall (
      .clk      (clk),
      .rst      (rst),
      .hall_raw (hall_raw),
      .hall_db  (hall_db),
      .hall_prev(hall_prev),
      .hall_edge(hall_edge)
   );

   // An edge out of an invalid code (e.g. the 000 seen at power-up) starts a fresh forward run
   assign fwd_edge  = hall_edge && hall_valid(hall_db) &&
                      (!hall_valid(hall_prev) || (hall_db == hall_next(hall_prev)));
   assign step_done = (cyc_q == CW'(RAMP_STEP_CYCLES - 1));

   always_comb begin
      st_n    = state;
      cyc_n   = cyc_q;
      idx_n   = idx_q;
      steps_n = steps_q;
      hand_n  = hand_q;
      per_n   = per_q;
      stall_n = stall_q;
      sp_n    = speed_period;
      fc_n    = fault_code;
      pv_n    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable) begin
               st_n  = ST_ALIGN;
               cyc_n = '0;
            end
         end
         ST_ALIGN: begin
            if (!enable) begin
               st_n = ST_IDLE;
            end else if (cyc_q == CW'(ALIGN_CYCLES - 1)) begin
               st_n    = ST_RAMP;
               cyc_n   = '0;
               idx_n   = '0;
               steps_n = '0;
               hand_n  = '0;
            end else begin
               cyc_n = cyc_q + 1'b1;
            end
         end
         ST_RAMP: begin
            if (!enable) begin
               st_n = ST_IDLE;
            end else begin
               if (hall_edge)
                  hand_n = fwd_edge ? hand_q + 1'b1 : '0;
               if (step_done) begin
                  cyc_n   = '0;
                  idx_n   = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
                  steps_n = steps_q + 1'b1;
               end else begin
                  cyc_n = cyc_q + 1'b1;
               end
               if (fwd_edge && (hand_q == HW'(HANDOFF_EDGES - 1))) begin
                  st_n    = ST_RUN;
                  per_n   = '0;
                  stall_n = '0;
               end else if (step_done && (steps_q == SW'(RAMP_STEPS_MAX - 1))) begin
                  st_n = ST_FAULT;
                  fc_n = FC_START;
               end
            end
         end
         ST_RUN: begin
            if (per_q != '1)
               per_n = per_q + 1'b1;
            stall_n = stall_q + 1'b1;
            if (!enable) begin
               st_n = ST_IDLE;
            end else if (!hall_valid(hall_db)) begin
               st_n = ST_FAULT;
               fc_n = FC_HALL;
            end else if (hall_edge) begin
               sp_n    = per_q;
               pv_n    = 1'b1;
               per_n   = PERIOD_W'(1);
               stall_n = '0;
            end else if (stall_q == TW'(STALL_CYCLES - 1)) begin
               st_n = ST_FAULT;
               fc_n = FC_STALL;
            end
         end
         ST_FAULT: begin
            if (clear_fault && !enable) begin
               st_n = ST_IDLE;
               fc_n = FC_NONE;
            end
         end
         default: st_n = ST_IDLE;
      endcase

      case (st_n)
         ST_ALIGN: ph_n = 3'b001;
         ST_RAMP:  ph_n = hall_to_phase(FWD_ORDER[idx_n]);
         ST_RUN:   ph_n = hall_to_phase(hall_db);
         default:  ph_n = 3'b000;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         phase_en     <= '0;
         running      <= 1'b0;
         fault        <= 1'b0;
         fault_code   <= FC_NONE;
         speed_period <= '0;
         period_valid <= 1'b0;
         cyc_q        <= '0;
         idx_q        <= '0;
         steps_q      <= '0;
         hand_q       <= '0;
         per_q        <= '0;
         stall_q      <= '0;
      end else begin
         state        <= st_n;
         phase_en     <= ph_n;
         running      <= (st_n == ST_RUN);
         fault        <= (st_n == ST_FAULT);
         fault_code   <= fc_n;
         speed_period <= sp_n;
         period_valid <= pv_n;
         cyc_q        <= cyc_n;
         idx_q        <= idx_n;
         steps_q      <= steps_n;
         hand_q       <= hand_n;
         per_q        <= per_n;
         stall_q      <= stall_n;
      end
   end

endmodule
